// File: rtl/jk_pkg.sv
// Shared types for the JK command sequencer: opcodes, FSM states, the
// queued command record and the JK next-state function.
package jk_pkg;

   // Widest repeat count a command record can carry; narrower CNT_W
   // values are zero-extended into it.
   localparam int unsigned JK_CNT_W_MAX = 16;

   typedef logic [JK_CNT_W_MAX-1:0] cnt_t;

   // Opcode encoding doubles as the {j,k} drive pair.
   typedef enum logic [1:0] {
      HOLD   = 2'b00,
      RESET  = 2'b01,
      SET    = 2'b10,
      TOGGLE = 2'b11
   } op_t;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   typedef struct packed {
      op_t  op;
      cnt_t cnt;
   } cmd_t;

   // JK truth table applied to the current q.
   function automatic logic next_q(input op_t op, input logic q);
      logic nq;
      nq = q;
      case (op)
         HOLD:    nq = q;
         RESET:   nq = 1'b0;
         SET:     nq = 1'b1;
         TOGGLE:  nq = ~q;
         default: nq = q;
      endcase
      return nq;
   endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO with push/pop/flush and full/empty flags.
// DEPTH must be a power of two and at least 2; pointers carry one extra
// wrap bit so full and empty are distinguished without a counter.
module jk_cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   input  logic         flush,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_q;
   logic [AW:0]  rd_q;
   logic         do_push;
   logic         do_pop;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign dout    = mem[rd_q[AW-1:0]];

   // Pointer update; flush discards everything, including a same-cycle push.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else if (flush) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

   // Storage write; contents need no reset because empty gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/jk_cmd_seq.sv
// JK command sequencer: queues opcode+repeat commands and replays each as
// cnt+1 registered j/k cycles with no bubbles between queued commands.
// Optional flop-output checker enabled by defining JK_CMD_CHECK_EN.
// CNT_W may be at most jk_pkg::JK_CNT_W_MAX.
module jk_cmd_seq
   import jk_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [1:0]       in_op,
   input  logic [CNT_W-1:0] in_cnt,
   output logic             in_ready,
   input  logic             flush,
   output logic             j,
   output logic             k,
   output logic             busy,
   input  logic             q_fb,
   output logic             err
);

   localparam int unsigned CMD_W = $bits(cmd_t);

   cmd_t       push_cmd;
   cmd_t       head;
   logic [CMD_W-1:0] fifo_dout;
   logic       fifo_full;
   logic       fifo_empty;
   logic       pop;

   state_t     state_q, state_d;
   op_t        op_q, op_d;
   cnt_t       cnt_q, cnt_d;
   logic       j_d, k_d;

   assign push_cmd = '{op: op_t'(in_op), cnt: cnt_t'(in_cnt)};
   assign head     = cmd_t'(fifo_dout);
   assign in_ready = !fifo_full;
   assign busy     = (state_q == ISSUE) || !fifo_empty;

   jk_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (CMD_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid),
      .din   (push_cmd),
      .pop   (pop),
      .flush (flush),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next-state, pop and j/k drive; the counter holds the cycles still to
   // issue after the current one, so reloading at zero gives back-to-back runs.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      j_d     = 1'b0;
      k_d     = 1'b0;
      pop     = 1'b0;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  state_d    = ISSUE;
                  op_d       = head.op;
                  cnt_d      = head.cnt;
                  {j_d, k_d} = head.op;
               end
            end
            ISSUE: begin
               if (cnt_q != '0) begin
                  cnt_d      = cnt_q - 1'b1;
                  {j_d, k_d} = op_q;
               end else if (!fifo_empty) begin
                  pop        = 1'b1;
                  op_d       = head.op;
                  cnt_d      = head.cnt;
                  {j_d, k_d} = head.op;
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, command and registered j/k outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         op_q    <= HOLD;
         cnt_q   <= '0;
         j       <= 1'b0;
         k       <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         j       <= j_d;
         k       <= k_d;
      end
   end

`ifdef JK_CMD_CHECK_EN
   logic exp_q;
   logic chk_v;
   logic err_q;

   // Track the flop's expected q per issue cycle, then compare against q_fb
   // in the following cycle, when the flop has captured that issue.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_q <= 1'b0;
         chk_v <= 1'b0;
         err_q <= 1'b0;
      end else begin
         if (state_q == ISSUE) exp_q <= next_q(op_q, exp_q);
         chk_v <= (state_q == ISSUE);
         if (chk_v && (q_fb != exp_q)) err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   logic q_fb_unused;
   assign q_fb_unused = q_fb;
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Directed bench for jk_cmd_seq with a behavioural JK flop on q_fb.
// Checker expectations follow JK_CMD_CHECK_EN when it is defined.
module tb_jk_cmd_seq;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 4;
`ifdef JK_CMD_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_RST  = 2'b01;
   localparam logic [1:0] OP_SET  = 2'b10;
   localparam logic [1:0] OP_TGL  = 2'b11;

   logic             clk      = 1'b0;
   logic             rst      = 1'b0;
   logic             in_valid = 1'b0;
   logic [1:0]       in_op    = 2'b00;
   logic [CNT_W-1:0] in_cnt   = '0;
   logic             flush    = 1'b0;
   logic             force_q0 = 1'b0;
   logic             fq;
   logic             q_fb;
   logic             in_ready, j, k, busy, err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // Behavioural JK flop fed by the sequencer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) fq <= 1'b0;
      else begin
         case ({j, k})
            2'b01:   fq <= 1'b0;
            2'b10:   fq <= 1'b1;
            2'b11:   fq <= ~fq;
            default: fq <= fq;
         endcase
      end
   end

   assign q_fb = force_q0 ? 1'b0 : fq;

   jk_cmd_seq #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_op    (in_op),
      .in_cnt   (in_cnt),
      .in_ready (in_ready),
      .flush    (flush),
      .j        (j),
      .k        (k),
      .busy     (busy),
      .q_fb     (q_fb),
      .err      (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer a command and return one sample point after it is accepted.
   task automatic push(input logic [1:0] op, input logic [CNT_W-1:0] c);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_op    = op;
      in_cnt   = c;
      while (!in_ready && n < 500) begin
         step();
         n++;
      end
      if (!in_ready) check("push_timeout", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      step();
      check("rst_jk", {30'd0, j, k}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      rst = 1'b1;
   endtask

   logic [1:0] t4_ops [6];
   int waited;
   int blk;

   initial begin
      // Reset held with a command on offer: nothing may be accepted.
      in_valid = 1'b1;
      in_op    = OP_SET;
      in_cnt   = 4'd0;
      step(); step(); step();
      check("r_jk", {30'd0, j, k}, 32'd0);
      check("r_ready", {31'd0, in_ready}, 32'd1);
      check("r_busy", {31'd0, busy}, 32'd0);
      check("r_err", {31'd0, err}, 32'd0);
      rst = 1'b1;
      step();
      in_valid = 1'b0;
      check("r_acc_busy", {31'd0, busy}, 32'd1);
      check("r_acc_jk", {30'd0, j, k}, 32'd0);
      step();
      check("r_iss_jk", {30'd0, j, k}, 32'b10);
      step();
      check("r_end_jk", {30'd0, j, k}, 32'd0);
      check("r_end_busy", {31'd0, busy}, 32'd0);

      // SET cnt=2: three cycles of 10 starting one cycle after acceptance.
      push(OP_SET, 4'd2);
      check("t2_lat_jk", {30'd0, j, k}, 32'd0);
      check("t2_lat_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t2_jk", {30'd0, j, k}, 32'b10);
         check("t2_busy", {31'd0, busy}, 32'd1);
      end
      step();
      check("t2_end_jk", {30'd0, j, k}, 32'd0);
      check("t2_end_busy", {31'd0, busy}, 32'd0);

      // TOGGLE cnt=0 then RESET cnt=1 back-to-back from q=0.
      do_reset();
      push(OP_TGL, 4'd0);
      push(OP_RST, 4'd1);
      check("t3_jk0", {30'd0, j, k}, 32'b11);
      step();
      check("t3_jk1", {30'd0, j, k}, 32'b01);
      check("t3_q0", {31'd0, q_fb}, 32'd1);
      step();
      check("t3_jk2", {30'd0, j, k}, 32'b01);
      check("t3_q1", {31'd0, q_fb}, 32'd0);
      step();
      check("t3_jk3", {30'd0, j, k}, 32'd0);
      check("t3_q2", {31'd0, q_fb}, 32'd0);
      check("t3_busy", {31'd0, busy}, 32'd0);
      step();
      check("t3_err", {31'd0, err}, 32'd0);

      // DEPTH+2 commands of cnt=15; the first issues at once, four fill the FIFO.
      t4_ops[0] = OP_SET;  t4_ops[1] = OP_RST; t4_ops[2] = OP_TGL;
      t4_ops[3] = OP_HOLD; t4_ops[4] = OP_SET; t4_ops[5] = OP_TGL;
      for (int i = 0; i < 5; i++) push(t4_ops[i], 4'd15);
      check("t4_full", {31'd0, in_ready}, 32'd0);
      // Edge numbering from the first accept (e0): the FIFO frees at e17 when
      // the first command's 16 cycles end, so ready is low for 13 samples.
      in_valid = 1'b1;
      in_op    = t4_ops[5];
      in_cnt   = 4'd15;
      waited   = 0;
      while (!in_ready && waited < 100) begin
         step();
         waited++;
      end
      check("t4_wait", waited, 32'd13);
      step();
      in_valid = 1'b0;
      // Now at e18; command n issues over edges 16n+1 .. 16n+16.
      for (int e = 18; e <= 98; e++) begin
         blk = (e - 1) / 16;
         check("t4_jk", {30'd0, j, k}, (blk < 6) ? {30'd0, t4_ops[blk]} : 32'd0);
         check("t4_busy", {31'd0, busy}, (blk < 6) ? 32'd1 : 32'd0);
         step();
      end

      // Flush mid-issue with two queued and a push in the same cycle.
      push(OP_SET, 4'd15);
      push(OP_RST, 4'd1);
      push(OP_TGL, 4'd1);
      check("t5_pre_busy", {31'd0, busy}, 32'd1);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_op    = OP_TGL;
      in_cnt   = 4'd3;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("t5_jk", {30'd0, j, k}, 32'd0);
      check("t5_busy", {31'd0, busy}, 32'd0);
      check("t5_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 20; i++) begin
         step();
         check("t5_quiet_jk", {30'd0, j, k}, 32'd0);
         check("t5_quiet_busy", {31'd0, busy}, 32'd0);
      end
      check("t5_err", {31'd0, err}, 32'd0);

      // Forced mismatch: SET issued while q_fb is held at 0.
      do_reset();
      force_q0 = 1'b1;
      push(OP_SET, 4'd0);
      check("t6_err_a", {31'd0, err}, 32'd0);
      step();
      check("t6_jk", {30'd0, j, k}, 32'b10);
      check("t6_err_b", {31'd0, err}, 32'd0);
      step();
      check("t6_err_c", {31'd0, err}, 32'd0);
      step();
      check("t6_err_set", {31'd0, err}, {31'd0, CHK});
      force_q0 = 1'b0;
      push(OP_TGL, 4'd1);
      for (int i = 0; i < 6; i++) step();
      check("t6_err_sticky", {31'd0, err}, {31'd0, CHK});
      do_reset();
      step();
      check("t6_err_clr", {31'd0, err}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
